tt_um_divider_recomposer: RTL and testbench

// Inverse companion of the unsigned divider: rebuilds the dividend from a
// (quotient, divisor, remainder) triple as quotient*divisor + remainder, using
// a sequential shift-and-add multiplier. It then checks the triple against an

---
 rtl/tt_um_divider_recomposer_if.sv | 28 ++
 rtl/tt_um_divider_recomposer.sv | 131 +++++++++++++
 tb/tb_tt_um_divider_recomposer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_divider_recomposer_if.sv
// Operand/result bundle for the divider recomposer.
// master: the requester (drives operands and start, reads results)
// slave:  the recomposer itself
interface tt_um_divider_recomposer_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     remainder;
    logic [WIDTH-1:0]     expected;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 overflow;
    logic                 remainder_err;
    logic                 match;

    modport master (
        output start, quotient, divisor, remainder, expected,
        input  busy, done, result, overflow, remainder_err, match
    );

    modport slave (
        input  start, quotient, divisor, remainder, expected,
        output busy, done, result, overflow, remainder_err, match
    );
endinterface

// File: rtl/tt_um_divider_recomposer.sv
// Divider recomposer: rebuilds dividend = quotient*divisor + remainder with a
// shift-and-add multiplier (one multiplier bit per cycle), then checks the
// triple against an expected dividend. All outputs are registered.
module tt_um_divider_recomposer #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_um_divider_recomposer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t               state_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     exp_r;
    logic                 rem_err_r;

    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 overflow_r;
    logic                 remainder_err_r;
    logic                 match_r;

    logic [2*WIDTH-1:0]   acc_add_s;
    logic                 last_iter_s;
    logic                 ovf_s;
    logic                 match_s;

    // Next accumulator value and the final-iteration flag computations
    always_comb begin
        acc_add_s   = acc_r;
        last_iter_s = 1'b0;
        ovf_s       = 1'b0;
        match_s     = 1'b0;
        if (mplier_r[0]) begin
            acc_add_s = acc_r + mcand_r;
        end else begin
            acc_add_s = acc_r;
        end
        last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
        ovf_s       = |acc_add_s[2*WIDTH-1:WIDTH];
        // Full-width compare, so any overflowed result can never match
        match_s     = (acc_add_s == {{WIDTH{1'b0}}, exp_r}) && !rem_err_r;
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= st_idle;
            acc_r           <= '0;
            mcand_r         <= '0;
            mplier_r        <= '0;
            cnt_r           <= '0;
            exp_r           <= '0;
            rem_err_r       <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            result_r        <= '0;
            overflow_r      <= 1'b0;
            remainder_err_r <= 1'b0;
            match_r         <= 1'b0;
        end else begin
            case (state_r)
                st_idle: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Only the latched copies are used from here on
                        acc_r     <= {{WIDTH{1'b0}}, bus.remainder};
                        mcand_r   <= {{WIDTH{1'b0}}, bus.divisor};
                        mplier_r  <= bus.quotient;
                        cnt_r     <= '0;
                        exp_r     <= bus.expected;
                        rem_err_r <= (bus.remainder >= bus.divisor);
                        busy_r    <= 1'b1;
                        state_r   <= st_calc;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= st_idle;
                    end
                end
                st_calc: begin
                    acc_r    <= acc_add_s;
                    mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        state_r         <= st_done;
                        busy_r          <= 1'b0;
                        done_r          <= 1'b1;
                        result_r        <= acc_add_s;
                        overflow_r      <= ovf_s;
                        remainder_err_r <= rem_err_r;
                        match_r         <= match_s;
                    end else begin
                        state_r <= st_calc;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                st_done: begin
                    // start is ignored here; the next request is taken in idle
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= st_idle;
                end
                default: begin
                    state_r <= st_idle;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.result        = result_r;
    assign bus.overflow      = overflow_r;
    assign bus.remainder_err = remainder_err_r;
    assign bus.match         = match_r;
endmodule

// File: tb/tb_tt_um_divider_recomposer.sv
// Bench for the divider recomposer: directed vector table, random operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_tt_um_divider_recomposer;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    tt_um_divider_recomposer_if #(.WIDTH(WIDTH)) bus ();

    tt_um_divider_recomposer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [7:0]  e;
        logic [15:0] res;
        logic        ovf;
        logic        rerr;
        logic        mat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the definition of the triple
    task automatic model(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] e, output logic [15:0] res, output logic ovf,
                         output logic rerr, output logic mat);
        int p;
        p    = int'(q) * int'(d) + int'(r);
        res  = p[15:0];
        ovf  = (p > 255);
        rerr = (int'(r) >= int'(d));
        mat  = (p == int'(e)) && !rerr;
    endtask

    // Issue one request from idle, scramble inputs after sampling, wait for done
    task automatic run_op(input string name, input logic [7:0] q, input logic [7:0] d,
                          input logic [7:0] r, input logic [7:0] e, input logic [15:0] x_res,
                          input logic x_ovf, input logic x_rerr, input logic x_mat);
        int  lat;
        bit  got;
        lat = 0;
        got = 1'b0;
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        bus.expected  = e;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.quotient  = 8'($urandom);
        bus.divisor   = 8'($urandom);
        bus.remainder = 8'($urandom);
        bus.expected  = 8'($urandom);
        check({name, "_busy_e0"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (k == 3) bus.start = 1'b1;
            if (k == 4) bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                lat = k;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, "_result"}, 32'(bus.result), 32'(x_res));
        check({name, "_overflow"}, 32'(bus.overflow), 32'(x_ovf));
        check({name, "_rem_err"}, 32'(bus.remainder_err), 32'(x_rerr));
        check({name, "_match"}, 32'(bus.match), 32'(x_mat));
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_result_hold"}, 32'(bus.result), 32'(x_res));
    endtask

    // Hard stop in case something above fails to return
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  q, d, r, e;
        logic [15:0] m_res;
        logic        m_ovf, m_rerr, m_mat;
        int pulses, overlaps, bad_gaps, bad_res, prev_k, dones;

        vecs[0] = '{8'd14,  8'd7,   8'd2,   8'd100, 16'd100,   1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'd13,  8'd15,  8'd5,   8'd200, 16'd200,   1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'd85,  8'd3,   8'd0,   8'd255, 16'd255,   1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'd5,   8'd3,   8'd0,   8'd255, 16'd15,    1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'd254, 8'd0,   16'd65279, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'd9,   8'd0,   8'd3,   8'd3,   16'd3,     1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'd2,   8'd4,   8'd4,   8'd12,  16'd12,    1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'd0,   8'd0,   8'd0,   8'd0,   16'd0,     1'b0, 1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.quotient  = 8'd0;
        bus.divisor   = 8'd0;
        bus.remainder = 8'd0;
        bus.expected  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_flags", {29'd0, bus.overflow, bus.remainder_err, bus.match}, 32'd0);
        rst_n = 1'b1;

        // start low keeps the block idle
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_start", {30'd0, bus.busy, bus.done}, 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].e,
                   vecs[i].res, vecs[i].ovf, vecs[i].rerr, vecs[i].mat);
        end

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            q = 8'($urandom);
            d = 8'($urandom);
            r = 8'($urandom_range(0, 255));
            e = (i % 3 == 0) ? 8'($urandom) : 8'(int'(q) * int'(d) + int'(r));
            model(q, d, r, e, m_res, m_ovf, m_rerr, m_mat);
            run_op($sformatf("rand%0d", i), q, d, r, e, m_res, m_ovf, m_rerr, m_mat);
        end

        // start held high: done every WIDTH+2 cycles, never with busy
        bus.quotient  = 8'd14;
        bus.divisor   = 8'd7;
        bus.remainder = 8'd2;
        bus.expected  = 8'd100;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        pulses = 0; overlaps = 0; bad_gaps = 0; bad_res = 0; prev_k = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (bus.done && bus.busy) overlaps++;
            if (bus.done) begin
                pulses++;
                if (bus.result != 16'd100) bad_res++;
                if (prev_k != 0 && (k - prev_k) != 10) bad_gaps++;
                if (prev_k == 0 && k != 8) bad_gaps++;
                prev_k = k;
            end
        end
        bus.start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd4);
        check("held_overlap", 32'(overlaps), 32'd0);
        check("held_gaps", 32'(bad_gaps), 32'd0);
        check("held_result", 32'(bad_res), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("held_drained_busy", 32'(bus.busy), 32'd0);

        // Reset during CALC aborts the operation
        run_op("pre_abort", 8'd14, 8'd7, 8'd2, 8'd100, 16'd100, 1'b0, 1'b0, 1'b1);
        bus.quotient  = 8'd255;
        bus.divisor   = 8'd255;
        bus.remainder = 8'd1;
        bus.expected  = 8'd0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flags", {29'd0, bus.overflow, bus.remainder_err, bus.match}, 32'd0);
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("post_abort", 8'd13, 8'd15, 8'd5, 8'd200, 16'd200, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
